// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and constants for the dual-issue controller: register
// addressing, controller states and the scoreboard width.
package dual_issue_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } issue_state_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam int        NUM_REGS = 32;

endpackage

// File: rtl/issue_hazard.sv
// Scoreboard check for one issue slot: clear when no source, and no written
// destination, has a pending long-latency write. r0 is never considered busy.
module issue_hazard
  import dual_issue_ctrl_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_busy_vec,
  input  logic                i_wen,
  input  reg_addr_t           i_rs,
  input  reg_addr_t           i_rt,
  input  reg_addr_t           i_rd,
  output logic                o_clear
);

  logic w_rs_busy;
  logic w_rt_busy;
  logic w_rd_busy;

  assign w_rs_busy = (i_rs != REG_ZERO) && i_busy_vec[i_rs];
  assign w_rt_busy = (i_rt != REG_ZERO) && i_busy_vec[i_rt];
  assign w_rd_busy = i_wen && (i_rd != REG_ZERO) && i_busy_vec[i_rd];

  assign o_clear = !w_rs_busy && !w_rt_busy && !w_rd_busy;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: slot A (master) and slot B (slave) issue grants
// against a long-latency scoreboard, with flush/drain handling.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int DUAL_EN  = 1,
  parameter int LONG_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic        a_wen,
  input  logic        a_long,
  input  reg_addr_t   a_rs,
  input  reg_addr_t   a_rt,
  input  reg_addr_t   a_rd,
  input  logic        b_valid,
  input  logic        b_wen,
  input  logic        b_long,
  input  reg_addr_t   b_rs,
  input  reg_addr_t   b_rt,
  input  reg_addr_t   b_rd,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_a_en,
  input  logic        wb_b_en,
  input  reg_addr_t   wb_a_addr,
  input  reg_addr_t   wb_b_addr,
  output logic        issue_a,
  output logic        issue_b,
  output logic [31:0] busy_vec,
  output logic [2:0]  inflight,
  output logic        draining,
  output logic [31:0] stall_cnt
);

  localparam logic       DUAL = (DUAL_EN != 0);
  localparam logic [3:0] LMAX = 4'(LONG_MAX);

  issue_state_t        r_state;
  logic [NUM_REGS-1:0] r_busy_vec;
  logic [2:0]          r_inflight;
  logic [31:0]         r_stall_cnt;

  logic                w_a_clear;
  logic                w_b_clear;
  logic [3:0]          w_infl_ext;
  logic                w_a_long_ok;
  logic                w_b_long_ok;
  logic                w_b_raw;
  logic                w_b_waw;
  logic                w_issue_a;
  logic                w_issue_b;
  logic                w_a_long_iss;
  logic                w_b_long_iss;
  logic                w_wb_a_hit;
  logic                w_wb_b_hit;
  logic [2:0]          w_longs;
  logic [2:0]          w_wb_cnt;
  logic [2:0]          w_infl_sum;
  logic [2:0]          w_infl_next;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  issue_hazard u_hazard_a (
    .i_busy_vec (r_busy_vec),
    .i_wen      (a_wen),
    .i_rs       (a_rs),
    .i_rt       (a_rt),
    .i_rd       (a_rd),
    .o_clear    (w_a_clear)
  );

  issue_hazard u_hazard_b (
    .i_busy_vec (r_busy_vec),
    .i_wen      (b_wen),
    .i_rs       (b_rs),
    .i_rt       (b_rt),
    .i_rd       (b_rd),
    .o_clear    (w_b_clear)
  );

  assign w_infl_ext  = {1'b0, r_inflight};
  assign w_a_long_ok = !a_long || (w_infl_ext < LMAX);
  // B's long op is counted behind A's, which has already been granted.
  assign w_b_long_ok = !b_long || ((w_infl_ext + {3'b000, a_long}) < LMAX);

  assign w_b_raw = a_wen && (a_rd != REG_ZERO) && ((a_rd == b_rs) || (a_rd == b_rt));
  // Same-rd short pairs are allowed: B's write lands last in the regfile.
  assign w_b_waw = a_wen && b_wen && (a_rd != REG_ZERO) && (a_rd == b_rd) && (a_long || b_long);

  assign w_issue_a = !rst && (r_state == RUN) && !flush && ex_ready && a_valid &&
                     w_a_clear && w_a_long_ok;
  assign w_issue_b = DUAL && w_issue_a && b_valid && w_b_clear && w_b_long_ok &&
                     !w_b_raw && !w_b_waw;

  assign w_a_long_iss = w_issue_a && a_long;
  assign w_b_long_iss = w_issue_b && b_long;

  // Writebacks only count against a pending entry; a duplicate port B hit is dropped.
  assign w_wb_a_hit = wb_a_en && (wb_a_addr != REG_ZERO) && r_busy_vec[wb_a_addr] &&
                      (r_inflight != 3'd0);
  assign w_wb_b_hit = wb_b_en && (wb_b_addr != REG_ZERO) && r_busy_vec[wb_b_addr] &&
                      (r_inflight != 3'd0) && !(w_wb_a_hit && (wb_b_addr == wb_a_addr));

  assign w_longs     = {2'b00, w_a_long_iss} + {2'b00, w_b_long_iss};
  assign w_wb_cnt    = {2'b00, w_wb_a_hit} + {2'b00, w_wb_b_hit};
  assign w_infl_sum  = r_inflight + w_longs;
  assign w_infl_next = (w_infl_sum > w_wb_cnt) ? (w_infl_sum - w_wb_cnt) : 3'd0;

  genvar gi;
  assign w_set[0] = 1'b0;
  assign w_clr[0] = 1'b0;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      assign w_set[gi] = (w_a_long_iss && a_wen && (a_rd == reg_addr_t'(gi))) ||
                         (w_b_long_iss && b_wen && (b_rd == reg_addr_t'(gi)));
      assign w_clr[gi] = (w_wb_a_hit && (wb_a_addr == reg_addr_t'(gi))) ||
                         (w_wb_b_hit && (wb_b_addr == reg_addr_t'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_busy_vec  <= '0;
      r_inflight  <= 3'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_busy_vec <= (r_busy_vec & ~w_clr) | w_set;
      r_inflight <= w_infl_next;
      if (a_valid && !w_issue_a) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      case (r_state)
        RUN:     if (flush) r_state <= DRAIN;
        DRAIN:   if ((r_inflight == 3'd0) && !flush) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign issue_a   = w_issue_a;
  assign issue_b   = w_issue_b;
  assign busy_vec  = r_busy_vec;
  assign inflight  = r_inflight;
  assign draining  = (r_state == DRAIN);
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: two instances (dual/LONG_MAX=4 and single/LONG_MAX=2)
// share stimulus and are checked against a queue-based pending-write model.
module tb_dual_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, a_valid, a_wen, a_long, b_valid, b_wen, b_long;
  logic [4:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd, wb_a_addr, wb_b_addr;
  logic       ex_ready, flush, wb_a_en, wb_b_en;

  logic        ia_o [2];
  logic        ib_o [2];
  logic [31:0] busy_o [2];
  logic [2:0]  infl_o [2];
  logic        drn_o [2];
  logic [31:0] stall_o [2];

  dual_issue_ctrl #(.DUAL_EN(1), .LONG_MAX(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wen(a_wen), .a_long(a_long), .a_rs(a_rs), .a_rt(a_rt), .a_rd(a_rd),
    .b_valid(b_valid), .b_wen(b_wen), .b_long(b_long), .b_rs(b_rs), .b_rt(b_rt), .b_rd(b_rd),
    .ex_ready(ex_ready), .flush(flush),
    .wb_a_en(wb_a_en), .wb_b_en(wb_b_en), .wb_a_addr(wb_a_addr), .wb_b_addr(wb_b_addr),
    .issue_a(ia_o[0]), .issue_b(ib_o[0]), .busy_vec(busy_o[0]), .inflight(infl_o[0]),
    .draining(drn_o[0]), .stall_cnt(stall_o[0])
  );

  dual_issue_ctrl #(.DUAL_EN(0), .LONG_MAX(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wen(a_wen), .a_long(a_long), .a_rs(a_rs), .a_rt(a_rt), .a_rd(a_rd),
    .b_valid(b_valid), .b_wen(b_wen), .b_long(b_long), .b_rs(b_rs), .b_rt(b_rt), .b_rd(b_rd),
    .ex_ready(ex_ready), .flush(flush),
    .wb_a_en(wb_a_en), .wb_b_en(wb_b_en), .wb_a_addr(wb_a_addr), .wb_b_addr(wb_b_addr),
    .issue_a(ia_o[1]), .issue_b(ib_o[1]), .busy_vec(busy_o[1]), .inflight(infl_o[1]),
    .draining(drn_o[1]), .stall_cnt(stall_o[1])
  );

  // Reference model: each instance keeps a list of outstanding long ops by
  // destination (0 when the op writes nothing trackable).
  int          lmax_m [2] = '{4, 2};
  bit          dual_m [2] = '{1'b1, 1'b0};
  logic [4:0]  pend [2][$];
  bit          drain_m [2];
  logic [31:0] stall_m [2];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic bit m_busy(int k, logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < pend[k].size(); i++)
      if (pend[k][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_busy_vec(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < pend[k].size(); i++)
      if (pend[k][i] != 5'd0) v[pend[k][i]] = 1'b1;
    return v;
  endfunction

  function automatic bit m_issue_a(int k);
    if (rst || drain_m[k] || flush || !ex_ready || !a_valid) return 1'b0;
    if (m_busy(k, a_rs) || m_busy(k, a_rt)) return 1'b0;
    if (a_wen && m_busy(k, a_rd)) return 1'b0;
    if (a_long && pend[k].size() >= lmax_m[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_issue_b(int k, bit ia);
    if (!dual_m[k] || !ia || !b_valid) return 1'b0;
    if (m_busy(k, b_rs) || m_busy(k, b_rt)) return 1'b0;
    if (b_wen && m_busy(k, b_rd)) return 1'b0;
    if (b_long && (pend[k].size() + (a_long ? 1 : 0)) >= lmax_m[k]) return 1'b0;
    if (a_wen && a_rd != 5'd0 && (a_rd == b_rs || a_rd == b_rt)) return 1'b0;
    if (a_wen && b_wen && a_rd != 5'd0 && a_rd == b_rd && (a_long || b_long)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_retire(int k, logic [4:0] addr);
    if (addr == 5'd0) return;
    for (int i = 0; i < pend[k].size(); i++)
      if (pend[k][i] == addr) begin
        pend[k].delete(i);
        return;
      end
  endfunction

  // Advance one clock and apply the same cycle to the model.
  task automatic tick();
    bit ia [2];
    bit ib [2];
    int sz;
    for (int k = 0; k < 2; k++) begin
      ia[k] = m_issue_a(k);
      ib[k] = m_issue_b(k, ia[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k].delete();
        drain_m[k] = 1'b0;
        stall_m[k] = 32'd0;
      end else begin
        sz = pend[k].size();
        if (a_valid && !ia[k]) stall_m[k] = stall_m[k] + 32'd1;
        if (wb_a_en) m_retire(k, wb_a_addr);
        if (wb_b_en) m_retire(k, wb_b_addr);
        if (ia[k] && a_long) pend[k].push_back(a_wen ? a_rd : 5'd0);
        if (ib[k] && b_long) pend[k].push_back(b_wen ? b_rd : 5'd0);
        if (!drain_m[k] && flush) drain_m[k] = 1'b1;
        else if (drain_m[k] && sz == 0 && !flush) drain_m[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; a_valid = 0; a_wen = 0; a_long = 0; a_rs = 0; a_rt = 0; a_rd = 0;
    b_valid = 0; b_wen = 0; b_long = 0; b_rs = 0; b_rt = 0; b_rd = 0;
    ex_ready = 1; flush = 0; wb_a_en = 0; wb_b_en = 0; wb_a_addr = 0; wb_b_addr = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    a_valid = 1; a_wen = 1; a_rs = 1; a_rt = 2; a_rd = 3; b_valid = 1; b_wen = 1; b_rd = 8;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ia_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_issue_a[%0d]: got %b want 0", k, ia_o[k]); end
      n_cmp++; if (ib_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_issue_b[%0d]: got %b want 0", k, ib_o[k]); end
    end
    tick(); idle(); #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (busy_o[k] !== 32'd0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %h want 0", k, busy_o[k]); end
      n_cmp++; if (infl_o[k] !== 3'd0) begin n_fail++; $display("FAIL reset_inflight[%0d]: got %0d want 0", k, infl_o[k]); end
      n_cmp++; if (stall_o[k] !== 32'd0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %0d want 0", k, stall_o[k]); end
      n_cmp++; if (drn_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_draining[%0d]: got %b want 0", k, drn_o[k]); end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    a_valid = 1; a_wen = 1; a_rs = 1; a_rt = 2; a_rd = 3; #2;
    n_cmp++; if (ia_o[0] !== 1'b1) begin n_fail++; $display("FAIL basic_issue_a: got %b want 1", ia_o[0]); end
    tick(); idle(); #2;
    n_cmp++; if (busy_o[0] !== 32'd0) begin n_fail++; $display("FAIL basic_busy: got %h want 0", busy_o[0]); end
    n_cmp++; if (infl_o[0] !== 3'd0) begin n_fail++; $display("FAIL basic_inflight: got %0d want 0", infl_o[0]); end
    $display("test_basic done");
  endtask

  task automatic test_load_use();
    do_reset();
    a_valid = 1; a_wen = 1; a_long = 1; a_rd = 5; #2;
    n_cmp++; if (ia_o[0] !== 1'b1) begin n_fail++; $display("FAIL load_issue: got %b want 1", ia_o[0]); end
    tick();
    a_long = 0; a_rs = 5; a_rd = 8;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (ia_o[0] !== 1'b0) begin n_fail++; $display("FAIL use_blocked c%0d: got %b want 0", c, ia_o[0]); end
      n_cmp++; if (stall_o[0] !== 32'(c)) begin n_fail++; $display("FAIL use_stall c%0d: got %0d want %0d", c, stall_o[0], c); end
      n_cmp++; if (busy_o[0] !== 32'h20) begin n_fail++; $display("FAIL use_busy c%0d: got %h want 20", c, busy_o[0]); end
      tick();
    end
    wb_a_en = 1; wb_a_addr = 5; #2;
    n_cmp++; if (ia_o[0] !== 1'b0) begin n_fail++; $display("FAIL wb_same_cycle: got %b want 0", ia_o[0]); end
    tick(); wb_a_en = 0; #2;
    n_cmp++; if (ia_o[0] !== 1'b1) begin n_fail++; $display("FAIL use_resume: got %b want 1", ia_o[0]); end
    n_cmp++; if (stall_o[0] !== 32'd4) begin n_fail++; $display("FAIL use_stall_total: got %0d want 4", stall_o[0]); end
    n_cmp++; if (infl_o[0] !== 3'd0) begin n_fail++; $display("FAIL use_inflight: got %0d want 0", infl_o[0]); end
    tick(); idle();
    $display("test_load_use done");
  endtask

  task automatic test_b_hazard();
    do_reset();
    a_valid = 1; a_wen = 1; a_rs = 1; a_rt = 2; a_rd = 4;
    b_valid = 1; b_wen = 1; b_rs = 4; b_rt = 0; b_rd = 5; #2;
    n_cmp++; if (ia_o[0] !== 1'b1) begin n_fail++; $display("FAIL raw_issue_a: got %b want 1", ia_o[0]); end
    n_cmp++; if (ib_o[0] !== 1'b0) begin n_fail++; $display("FAIL raw_rs_issue_b: got %b want 0", ib_o[0]); end
    b_rs = 6; b_rt = 4; #1;
    n_cmp++; if (ib_o[0] !== 1'b0) begin n_fail++; $display("FAIL raw_rt_issue_b: got %b want 0", ib_o[0]); end
    b_rt = 7; #1;
    n_cmp++; if (ib_o[0] !== 1'b1) begin n_fail++; $display("FAIL nohaz_issue_b: got %b want 1", ib_o[0]); end
    n_cmp++; if (ib_o[1] !== 1'b0) begin n_fail++; $display("FAIL single_issue_b: got %b want 0", ib_o[1]); end
    n_cmp++; if (ia_o[1] !== 1'b1) begin n_fail++; $display("FAIL single_issue_a: got %b want 1", ia_o[1]); end
    a_rd = 0; b_rs = 0; b_rt = 0; #1;
    n_cmp++; if (ib_o[0] !== 1'b1) begin n_fail++; $display("FAIL r0_no_raw: got %b want 1", ib_o[0]); end
    tick(); idle();
    $display("test_b_hazard done");
  endtask

  task automatic test_waw();
    do_reset();
    a_valid = 1; a_wen = 1; a_rd = 9; b_valid = 1; b_wen = 1; b_rd = 9; #2;
    n_cmp++; if (ia_o[0] !== 1'b1 || ib_o[0] !== 1'b1) begin n_fail++; $display("FAIL waw_short: got %b%b want 11", ia_o[0], ib_o[0]); end
    b_long = 1; #1;
    n_cmp++; if (ib_o[0] !== 1'b0) begin n_fail++; $display("FAIL waw_b_long: got %b want 0", ib_o[0]); end
    b_long = 0; a_long = 1; #1;
    n_cmp++; if (ib_o[0] !== 1'b0) begin n_fail++; $display("FAIL waw_a_long: got %b want 0", ib_o[0]); end
    a_long = 0; a_rd = 0; b_rd = 0; b_long = 1; a_long = 1; #1;
    n_cmp++; if (ib_o[0] !== 1'b1) begin n_fail++; $display("FAIL waw_r0: got %b want 1", ib_o[0]); end
    tick(); idle(); #2;
    n_cmp++; if (infl_o[0] !== 3'd2 || busy_o[0] !== 32'd0) begin n_fail++; $display("FAIL r0_long: got %0d/%h want 2/0", infl_o[0], busy_o[0]); end
    $display("test_waw done");
  endtask

  task automatic test_long_limit();
    do_reset();
    a_valid = 1; a_wen = 1; a_long = 1; a_rd = 10; #2;
    n_cmp++; if (ia_o[1] !== 1'b1) begin n_fail++; $display("FAIL limit_first: got %b want 1", ia_o[1]); end
    tick(); a_rd = 11; #2;
    n_cmp++; if (ia_o[1] !== 1'b1) begin n_fail++; $display("FAIL limit_second: got %b want 1", ia_o[1]); end
    tick(); a_rd = 12; #2;
    n_cmp++; if (ia_o[1] !== 1'b0) begin n_fail++; $display("FAIL limit_third: got %b want 0", ia_o[1]); end
    n_cmp++; if (infl_o[1] !== 3'd2) begin n_fail++; $display("FAIL limit_inflight: got %0d want 2", infl_o[1]); end
    tick(); wb_a_en = 1; wb_a_addr = 10; #2;
    n_cmp++; if (ia_o[1] !== 1'b0) begin n_fail++; $display("FAIL limit_wb_cycle: got %b want 0", ia_o[1]); end
    tick(); wb_a_en = 0; #2;
    n_cmp++; if (infl_o[1] !== 3'd1) begin n_fail++; $display("FAIL limit_after_wb: got %0d want 1", infl_o[1]); end
    n_cmp++; if (ia_o[1] !== 1'b1) begin n_fail++; $display("FAIL limit_resume: got %b want 1", ia_o[1]); end
    tick(); idle();
    $display("test_long_limit done");
  endtask

  task automatic test_flush_drain();
    do_reset();
    a_valid = 1; a_wen = 1; a_long = 1; a_rd = 6; b_valid = 1; b_wen = 1; b_long = 1; b_rd = 7; #2;
    n_cmp++; if (ia_o[0] !== 1'b1 || ib_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_issue: got %b%b want 11", ia_o[0], ib_o[0]); end
    tick(); idle(); flush = 1; a_valid = 1; a_rd = 1; #2;
    n_cmp++; if (ia_o[0] !== 1'b0) begin n_fail++; $display("FAIL flush_blocks: got %b want 0", ia_o[0]); end
    tick(); flush = 0; #2;
    n_cmp++; if (drn_o[0] !== 1'b1 || ia_o[0] !== 1'b0) begin n_fail++; $display("FAIL drain_state: got %b/%b want 1/0", drn_o[0], ia_o[0]); end
    n_cmp++; if (infl_o[0] !== 3'd2 || busy_o[0] !== 32'hC0) begin n_fail++; $display("FAIL drain_pending: got %0d/%h want 2/c0", infl_o[0], busy_o[0]); end
    tick(); wb_a_en = 1; wb_a_addr = 6; wb_b_en = 1; wb_b_addr = 7; #2;
    n_cmp++; if (drn_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_hold: got %b want 1", drn_o[0]); end
    tick(); wb_a_en = 0; wb_b_en = 0; #2;
    n_cmp++; if (infl_o[0] !== 3'd0 || busy_o[0] !== 32'd0) begin n_fail++; $display("FAIL drain_cleared: got %0d/%h want 0/0", infl_o[0], busy_o[0]); end
    n_cmp++; if (infl_o[1] !== 3'd0) begin n_fail++; $display("FAIL drain_no_underflow: got %0d want 0", infl_o[1]); end
    n_cmp++; if (drn_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_exit_timing: got %b want 1", drn_o[0]); end
    tick(); #2;
    n_cmp++; if (drn_o[0] !== 1'b0 || ia_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_to_run: got %b/%b want 0/1", drn_o[0], ia_o[0]); end
    tick(); idle();
    $display("test_flush_drain done");
  endtask

  task automatic test_random();
    bit exp_ia, exp_ib;
    int k0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 4);
      ex_ready = ($urandom_range(0, 99) < 85);
      a_valid  = ($urandom_range(0, 99) < 80);
      a_wen    = ($urandom_range(0, 99) < 90);
      a_long   = ($urandom_range(0, 99) < 30);
      a_rs = 5'($urandom_range(0, 15)); a_rt = 5'($urandom_range(0, 15)); a_rd = 5'($urandom_range(0, 15));
      b_valid  = ($urandom_range(0, 99) < 80);
      b_wen    = ($urandom_range(0, 99) < 90);
      b_long   = ($urandom_range(0, 99) < 30);
      b_rs = 5'($urandom_range(0, 15)); b_rt = 5'($urandom_range(0, 15)); b_rd = 5'($urandom_range(0, 15));
      k0 = $urandom_range(0, 1);
      wb_a_en = ($urandom_range(0, 99) < 35);
      wb_a_addr = (pend[k0].size() > 0) ? pend[k0][$urandom_range(0, pend[k0].size() - 1)] : 5'($urandom_range(0, 15));
      wb_b_en = ($urandom_range(0, 99) < 25);
      wb_b_addr = (pend[0].size() > 0) ? pend[0][$urandom_range(0, pend[0].size() - 1)] : 5'($urandom_range(0, 15));
      #2;
      for (int k = 0; k < 2; k++) begin
        exp_ia = m_issue_a(k);
        exp_ib = m_issue_b(k, exp_ia);
        n_cmp++; if (ia_o[k] !== exp_ia) begin n_fail++; $display("FAIL rnd_issue_a[%0d] cyc %0d: got %b want %b", k, c, ia_o[k], exp_ia); end
        n_cmp++; if (ib_o[k] !== exp_ib) begin n_fail++; $display("FAIL rnd_issue_b[%0d] cyc %0d: got %b want %b", k, c, ib_o[k], exp_ib); end
        n_cmp++; if (busy_o[k] !== m_busy_vec(k)) begin n_fail++; $display("FAIL rnd_busy[%0d] cyc %0d: got %h want %h", k, c, busy_o[k], m_busy_vec(k)); end
        n_cmp++; if (infl_o[k] !== 3'(pend[k].size())) begin n_fail++; $display("FAIL rnd_inflight[%0d] cyc %0d: got %0d want %0d", k, c, infl_o[k], pend[k].size()); end
        n_cmp++; if (drn_o[k] !== drain_m[k]) begin n_fail++; $display("FAIL rnd_draining[%0d] cyc %0d: got %b want %b", k, c, drn_o[k], drain_m[k]); end
        n_cmp++; if (stall_o[k] !== stall_m[k]) begin n_fail++; $display("FAIL rnd_stall[%0d] cyc %0d: got %0d want %0d", k, c, stall_o[k], stall_m[k]); end
      end
      tick();
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    for (int k = 0; k < 2; k++) begin
      drain_m[k] = 1'b0;
      stall_m[k] = 32'd0;
    end
    #1;
    test_reset();
    test_basic();
    test_load_use();
    test_b_hazard();
    test_waw();
    test_long_limit();
    test_flush_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
